// File: rtl/ram1_arb_pkg.sv
// Shared types and widths for the single-port RAM arbiter.
// Owner-state enum, RAM data/byte-enable widths, starvation counter width.
package ram1_arb_pkg;

  localparam int DATA_W       = 32;
  localparam int BE_W         = 4;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_IF_RD,
    OWN_LS_RD,
    OWN_LS_WR,
    OWN_ERR_IF,
    OWN_ERR_LS
  } owner_e;

endpackage

// File: rtl/ram1_arb_grant.sv
// Grant logic: picks fetch or load/store when both request in one cycle.
// Ports: clk, rst_n, if_valid, ls_valid -> grant_if, grant_ls.
// RAM1_ARB_RR_EN selects strict round-robin instead of priority+starvation.
module ram1_arb_grant
  import ram1_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

`ifdef RAM1_ARB_RR_EN
  // 1 = load/store was granted last, 0 = fetch (reset value)
  logic last_ls;

  assign grant_if = if_valid && (!ls_valid || last_ls);
  assign grant_ls = ls_valid && !grant_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls <= 1'b0;
    end else if (grant_if) begin
      last_ls <= 1'b0;
    end else if (grant_ls) begin
      last_ls <= 1'b1;
    end
  end
`else
  localparam logic [STARVE_CNT_W-1:0] LIMIT =
    STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    fetch_wins;

  assign fetch_wins = (starve_cnt == LIMIT);
  assign grant_if   = if_valid && (!ls_valid || fetch_wins);
  assign grant_ls   = ls_valid && !grant_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_valid || grant_if) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ram1_port_arbiter.sv
// Shares one 1-cycle-latency single-port RAM between fetch and load/store.
// Ports: if_req_*/if_rsp_*, ls_req_*/ls_rsp_*, ram_* pins. Macro: RAM1_ARB_RR_EN.
module ram1_port_arbiter
  import ram1_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 14,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rsp_rdata,
  output logic                  if_rsp_err,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [31:0]           ls_req_addr,
  input  logic                  ls_req_we,
  input  logic [BE_W-1:0]       ls_req_be,
  input  logic [DATA_W-1:0]     ls_req_wdata,
  output logic                  ls_rsp_valid,
  output logic [DATA_W-1:0]     ls_rsp_rdata,
  output logic                  ls_rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_wr_data,
  output logic                  ram_wr_en,
  output logic [BE_W-1:0]       ram_wr_byte_en,
  input  logic [DATA_W-1:0]     ram_rd_data
);

  localparam int WIN_LSB = ADDR_WIDTH + 2;

  logic        grant_if;
  logic        grant_ls;
  logic [31:0] req_addr;
  logic        hit;
  owner_e      owner;
  owner_e      owner_nxt;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^{if_req_addr[1:0], ls_req_addr[1:0]};

  ram1_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_valid(if_req_valid),
    .ls_valid(ls_req_valid),
    .grant_if(grant_if),
    .grant_ls(grant_ls)
  );

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  assign req_addr = grant_if ? if_req_addr : ls_req_addr;
  assign hit = (req_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);

  // Out-of-range or idle cycles leave every RAM pin at zero
  always_comb begin
    ram_addr       = '0;
    ram_wr_data    = '0;
    ram_wr_en      = 1'b0;
    ram_wr_byte_en = '0;
    if ((grant_if || grant_ls) && hit) begin
      ram_addr = req_addr[WIN_LSB-1:2];
      if (grant_ls && ls_req_we) begin
        ram_wr_en      = 1'b1;
        ram_wr_byte_en = ls_req_be;
        ram_wr_data    = ls_req_wdata;
      end
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    unique case (1'b1)
      grant_if: owner_nxt = hit ? OWN_IF_RD : OWN_ERR_IF;
      grant_ls: begin
        if (!hit)          owner_nxt = OWN_ERR_LS;
        else if (ls_req_we) owner_nxt = OWN_LS_WR;
        else                owner_nxt = OWN_LS_RD;
      end
      default: owner_nxt = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner        <= OWN_NONE;
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_err   <= 1'b0;
    end else begin
      owner        <= owner_nxt;
      if_rsp_valid <= (owner_nxt == OWN_IF_RD) ||
                      (owner_nxt == OWN_ERR_IF);
      if_rsp_err   <= (owner_nxt == OWN_ERR_IF);
      ls_rsp_valid <= (owner_nxt == OWN_LS_RD) ||
                      (owner_nxt == OWN_LS_WR) ||
                      (owner_nxt == OWN_ERR_LS);
      ls_rsp_err   <= (owner_nxt == OWN_ERR_LS);
    end
  end

  // RAM has no output register, so read data is steered straight through
  assign if_rsp_rdata = (owner == OWN_IF_RD) ? ram_rd_data : '0;
  assign ls_rsp_rdata = (owner == OWN_LS_RD) ? ram_rd_data : '0;

endmodule

// File: tb/tb_ram1_port_arbiter.sv
// Directed bench for ram1_port_arbiter with a 1-cycle-latency RAM model.
// Follows RAM1_ARB_RR_EN for the contention grant pattern.
module tb_ram1_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        if_rsp_err;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_req_addr;
  logic        ls_req_we;
  logic [3:0]  ls_req_be;
  logic [31:0] ls_req_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_rdata;
  logic        ls_rsp_err;
  logic [13:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_byte_en;
  logic [31:0] ram_rd_data;

  logic [31:0] mem [0:16383];

  int checks;
  int errors;

  ram1_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_rdata  (if_rsp_rdata),
    .if_rsp_err    (if_rsp_err),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_we     (ls_req_we),
    .ls_req_be     (ls_req_be),
    .ls_req_wdata  (ls_req_wdata),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_rdata  (ls_rsp_rdata),
    .ls_rsp_err    (ls_rsp_err),
    .ram_addr      (ram_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_byte_en(ram_wr_byte_en),
    .ram_rd_data   (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wr_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
      end
    end
    ram_rd_data <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    ls_req_valid = 1'b0;
    ls_req_addr  = '0;
    ls_req_we    = 1'b0;
    ls_req_be    = '0;
    ls_req_wdata = '0;
  endtask

  task automatic ls_drive(input logic [31:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] d);
    ls_req_valid = 1'b1;
    ls_req_addr  = a;
    ls_req_we    = we;
    ls_req_be    = be;
    ls_req_wdata = d;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int wait_cnt;
    int max_wait;
    logic exp_if;
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_if_valid", 32'(if_rsp_valid), 32'd0);
    check("rst_ls_valid", 32'(ls_rsp_valid), 32'd0);
    check("rst_if_err",   32'(if_rsp_err),   32'd0);
    check("rst_ls_err",   32'(ls_rsp_err),   32'd0);
    check("rst_if_rdata", if_rsp_rdata, 32'd0);
    check("rst_ls_rdata", ls_rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // preload words through full-word stores
    ls_drive(32'h0, 1'b1, 4'hF, 32'hA000_0000);
    @(negedge clk);
    ls_drive(32'h4, 1'b1, 4'hF, 32'hA000_0004);
    @(negedge clk);
    ls_drive(32'h8, 1'b1, 4'hF, 32'hA000_0008);
    @(negedge clk);
    ls_drive(32'h10, 1'b1, 4'hF, 32'h1122_3344);
    @(negedge clk);
    idle();
    @(negedge clk);

    // partial store then load of the same word
    ls_drive(32'h10, 1'b1, 4'b0011, 32'hAABB_CCDD);
    #1;
    check("st_ready",  32'(ls_req_ready), 32'd1);
    check("st_wr_en",  32'(ram_wr_en), 32'd1);
    check("st_addr",   32'(ram_addr), 32'd4);
    check("st_be",     32'(ram_wr_byte_en), 32'h3);
    check("st_wdata",  ram_wr_data, 32'hAABB_CCDD);
    @(negedge clk);
    ls_drive(32'h10, 1'b0, 4'h0, 32'h0);
    #1;
    check("st_rsp_v",   32'(ls_rsp_valid), 32'd1);
    check("st_rsp_d",   ls_rsp_rdata, 32'd0);
    check("st_rsp_e",   32'(ls_rsp_err), 32'd0);
    check("ld_wr_en",   32'(ram_wr_en), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("ld_rsp_v", 32'(ls_rsp_valid), 32'd1);
    check("ld_rsp_d", ls_rsp_rdata, 32'h1122_CCDD);
    check("ld_if_d",  if_rsp_rdata, 32'd0);
    @(negedge clk);
    #1;
    check("ld_done", 32'(ls_rsp_valid), 32'd0);

    // out-of-range fetch and store
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0001_0000;
    #1;
    check("oor_ready", 32'(if_req_ready), 32'd1);
    check("oor_addr",  32'(ram_addr), 32'd0);
    @(negedge clk);
    idle();
    ls_drive(32'h0002_0004, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #1;
    check("oor_if_v",  32'(if_rsp_valid), 32'd1);
    check("oor_if_e",  32'(if_rsp_err), 32'd1);
    check("oor_if_d",  if_rsp_rdata, 32'd0);
    check("oor_st_we", 32'(ram_wr_en), 32'd0);
    check("oor_st_be", 32'(ram_wr_byte_en), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("oor_ls_v", 32'(ls_rsp_valid), 32'd1);
    check("oor_ls_e", 32'(ls_rsp_err), 32'd1);
    @(negedge clk);

    // back-to-back fetches
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0;
    @(negedge clk);
    if_req_addr  = 32'h4;
    #1;
    check("b2b0_v", 32'(if_rsp_valid), 32'd1);
    check("b2b0_d", if_rsp_rdata, 32'hA000_0000);
    @(negedge clk);
    if_req_addr  = 32'h8;
    #1;
    check("b2b1_v", 32'(if_rsp_valid), 32'd1);
    check("b2b1_d", if_rsp_rdata, 32'hA000_0004);
    @(negedge clk);
    idle();
    #1;
    check("b2b2_v", 32'(if_rsp_valid), 32'd1);
    check("b2b2_d", if_rsp_rdata, 32'hA000_0008);
    check("b2b2_e", 32'(if_rsp_err), 32'd0);
    @(negedge clk);

    // contention from a clean reset
    do_reset();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0;
    ls_drive(32'h4, 1'b0, 4'h0, 32'h0);
    wait_cnt = 0;
    max_wait = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
`ifdef RAM1_ARB_RR_EN
      exp_if = (i % 2) == 1;
`else
      exp_if = (i % 5) == 4;
`endif
      check($sformatf("cont%0d_if", i), 32'(if_req_ready), 32'(exp_if));
      check($sformatf("cont%0d_ls", i), 32'(ls_req_ready), 32'(!exp_if));
      if (if_req_ready) wait_cnt = 0;
      else wait_cnt++;
      if (wait_cnt > max_wait) max_wait = wait_cnt;
      @(negedge clk);
    end
    check("max_wait_le4", 32'(max_wait > 4), 32'd0);
    idle();
    @(negedge clk);

    // reset hits a pending load before it can respond
    ls_drive(32'h10, 1'b0, 4'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_ready", 32'(ls_req_ready), 32'd1);
    @(negedge clk);
    check("mr_v0", 32'(ls_rsp_valid), 32'd0);
    idle();
    @(negedge clk);
    check("mr_v1", 32'(ls_rsp_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mr_post%0d", i), 32'(ls_rsp_valid), 32'd0);
      check($sformatf("mr_postd%0d", i), ls_rsp_rdata, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
